div_sign_sequencer: RTL and testbench

Front-end sequencer for the team's unsigned single-cycle `divider`, with a `start`/`ready` pulse interface. It accepts signed or unsigned divide requests over a valid/ready handshake and resolves divide-by-zero and signed overflow locally. All other requests are converted to magnitudes, issued to the divider, and the sign-corrected quotient and remainder are returned over a second valid/ready handshake. It sits directly upstream of the divider and drives its operands.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_sign_fix.sv | 12 +
 rtl/div_sign_sequencer.sv | 147 ++++++++++++++
 tb/tb_div_sign_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and width-generic constants for the signed divide sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_state_e;

  localparam int unsigned DIV_MAX_W = 64;

  // Constants are returned at the widest supported width; callers truncate to WIDTH.
  function automatic logic [DIV_MAX_W-1:0] DIV_ZERO_QUOT(input int unsigned w);
    DIV_ZERO_QUOT = (w >= DIV_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [DIV_MAX_W-1:0] DIV_MIN(input int unsigned w);
    DIV_MIN = 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] value_o
);

  assign value_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/div_sign_sequencer.sv
// Signed/unsigned front end for the unsigned divider: resolves /0 and MIN/-1 locally,
// otherwise issues magnitudes and sign-corrects the returned quotient and remainder.
module div_sign_sequencer
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic             out_overflow,
  output div_state_e       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // a producer holds valid and its payload stable until that edge.

  localparam logic [WIDTH-1:0] QUOT_ZERO = WIDTH'(DIV_ZERO_QUOT(WIDTH));
  localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(DIV_MIN(WIDTH));
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  div_state_e state_q, state_d;

  logic             accept, is_zero, is_ovf, dvd_neg, dvs_neg;
  logic [WIDTH-1:0] mag_dvd, mag_dvs, fix_quot, fix_rem;

  logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
  logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
  logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  assign accept  = in_valid && (state_q == IDLE);
  assign is_zero = (in_divisor == '0);
  assign is_ovf  = in_signed && (in_dividend == MIN_VAL) && (in_divisor == ALL_ONES);
  assign dvd_neg = in_signed && in_dividend[WIDTH-1];
  assign dvs_neg = in_signed && in_divisor[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_dvd (.value_i(in_dividend),   .negate_i(dvd_neg),    .value_o(mag_dvd));
  div_sign_fix #(.WIDTH(WIDTH)) u_mag_dvs (.value_i(in_divisor),    .negate_i(dvs_neg),    .value_o(mag_dvs));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.value_i(div_quotient),  .negate_i(quot_neg_q), .value_o(fix_quot));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value_i(div_remainder), .negate_i(rem_neg_q),  .value_o(fix_rem));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (is_zero || is_ovf) ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (div_ready) state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    div_start = (state_q == ISSUE);
    out_valid = (state_q == RESP);
  end

  // div_ready outside WAIT never touches the result registers, so stale pulses are harmless.
  always_comb begin
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    quot_neg_d      = quot_neg_q;
    rem_neg_d       = rem_neg_q;
    dbz_d           = dbz_q;
    ovf_d           = ovf_q;
    if (accept) begin
      dbz_d = 1'b0;
      ovf_d = 1'b0;
      if (is_zero) begin
        out_quotient_d  = QUOT_ZERO;
        out_remainder_d = in_dividend;
        dbz_d           = 1'b1;
      end else if (is_ovf) begin
        out_quotient_d  = in_dividend;
        out_remainder_d = '0;
        ovf_d           = 1'b1;
      end else begin
        div_dividend_d = mag_dvd;
        div_divisor_d  = mag_dvs;
        quot_neg_d     = dvd_neg ^ dvs_neg;
        rem_neg_d      = dvd_neg;
      end
    end else if ((state_q == WAIT) && div_ready) begin
      out_quotient_d  = fix_quot;
      out_remainder_d = fix_rem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      quot_neg_q      <= 1'b0;
      rem_neg_q       <= 1'b0;
      dbz_q           <= 1'b0;
      ovf_q           <= 1'b0;
    end else begin
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      quot_neg_q      <= quot_neg_d;
      rem_neg_q       <= rem_neg_d;
      dbz_q           <= dbz_d;
      ovf_q           <= ovf_d;
    end
  end

  assign div_dividend    = div_dividend_q;
  assign div_divisor     = div_divisor_q;
  assign out_quotient    = out_quotient_q;
  assign out_remainder   = out_remainder_q;
  assign out_div_by_zero = dbz_q;
  assign out_overflow    = ovf_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_div_sign_sequencer.sv
// Bench for div_sign_sequencer at WIDTH=8 with a behavioural single-cycle divider model.
module tb_div_sign_sequencer;
  import div_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_signed;
  logic [W-1:0] in_dividend, in_divisor;
  logic         div_start;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic         div_ready = 1'b0;
  logic         out_valid, out_ready;
  logic [W-1:0] out_quotient, out_remainder;
  logic         out_div_by_zero, out_overflow;
  div_state_e   dbg_state;

  div_sign_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_ready(div_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_by_zero(out_div_by_zero), .out_overflow(out_overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- divider model ----------------
  logic         stall = 1'b0;
  logic         pending = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;

  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (div_start) begin
      m_q <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
      m_r <= (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
      if (stall) pending <= 1'b1;
      else       div_ready <= 1'b1;
    end else if (pending && !stall) begin
      div_ready <= 1'b1;
      pending   <= 1'b0;
    end
  end
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {div_by_zero, overflow, quotient, remainder}
  logic [2*W+1:0] exp_q[$];
  logic [2*W+1:0] exp_e;

  function automatic logic [2*W+1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) return {2'b10, {W{1'b1}}, a};
    if (sgn && a == 8'h80 && b == 8'hFF) return {2'b01, a, {W{1'b0}}};
    if (sgn) begin
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {2'b00, q, r};
  endfunction

  int n_hs = 0;
  int n_start = 0;

  always @(negedge clk) begin
    if (div_start) n_start++;
    if (rst && out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("sb_quot", 32'(out_quotient),    32'(exp_e[2*W-1:W]));
        check_eq("sb_rem",  32'(out_remainder),   32'(exp_e[W-1:0]));
        check_eq("sb_dbz",  32'(out_div_by_zero), 32'(exp_e[2*W+1]));
        check_eq("sb_ovf",  32'(out_overflow),    32'(exp_e[2*W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int acc);
    int guard = 0;
    in_valid = 1'b1; in_signed = sgn; in_dividend = a; in_divisor = b;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    acc = cyc;
    exp_q.push_back(ref_div(sgn, a, b));
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counted with the accept cycle as cycle 0.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk); #1; g++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int acc, lat, s0, hs0;
  int accs[4];
  logic [W-1:0] snap_q, snap_r, ra, rb;
  logic rs;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_dividend = '0; in_divisor = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  32'(in_ready),        32'd1);
    check_eq("rst_out_valid", 32'(out_valid),       32'd0);
    check_eq("rst_div_start", 32'(div_start),       32'd0);
    check_eq("rst_quot",      32'(out_quotient),    32'd0);
    check_eq("rst_rem",       32'(out_remainder),   32'd0);
    check_eq("rst_flags",     32'({out_div_by_zero, out_overflow}), 32'd0);
    check_eq("rst_div_ops",   32'({div_dividend, div_divisor}),     32'd0);
    check_eq("rst_state",     32'(dbg_state),       32'(IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: signed -7 / 2
    send(1'b1, 8'hF9, 8'h02, acc);
    check_eq("t1_div_dvd",   32'(div_dividend), 32'd7);
    check_eq("t1_div_dvs",   32'(div_divisor),  32'd2);
    check_eq("t1_div_start", 32'(div_start),    32'd1);
    wait_valid(lat);
    check_eq("t1_latency", 32'(lat), 32'd3);
    check_eq("t1_quot", 32'(out_quotient),  32'hFD);
    check_eq("t1_rem",  32'(out_remainder), 32'hFF);
    check_eq("t1_flags", 32'({out_div_by_zero, out_overflow}), 32'd0);
    drain();

    // 2: unsigned 0xF9 / 2
    send(1'b0, 8'hF9, 8'h02, acc);
    check_eq("t2_div_dvd", 32'(div_dividend), 32'hF9);
    wait_valid(lat);
    check_eq("t2_quot", 32'(out_quotient),  32'h7C);
    check_eq("t2_rem",  32'(out_remainder), 32'h01);
    drain();

    // 3: divide by zero
    s0 = n_start;
    send(1'b1, 8'h0D, 8'h00, acc);
    wait_valid(lat);
    check_eq("t3_latency", 32'(lat), 32'd1);
    check_eq("t3_quot", 32'(out_quotient),    32'hFF);
    check_eq("t3_rem",  32'(out_remainder),   32'h0D);
    check_eq("t3_dbz",  32'(out_div_by_zero), 32'd1);
    drain();
    check_eq("t3_no_start", 32'(n_start - s0), 32'd0);

    // 4: signed overflow
    s0 = n_start;
    send(1'b1, 8'h80, 8'hFF, acc);
    wait_valid(lat);
    check_eq("t4_latency", 32'(lat), 32'd1);
    check_eq("t4_quot", 32'(out_quotient),  32'h80);
    check_eq("t4_rem",  32'(out_remainder), 32'h00);
    check_eq("t4_ovf",  32'(out_overflow),  32'd1);
    check_eq("t4_dbz",  32'(out_div_by_zero), 32'd0);
    drain();
    check_eq("t4_no_start", 32'(n_start - s0), 32'd0);

    // 5: backpressure, then back-to-back throughput
    out_ready = 1'b0;
    send(1'b1, 8'h9C, 8'h07, acc);
    wait_valid(lat);
    check_eq("t5_latency", 32'(lat), 32'd3);
    snap_q = out_quotient;
    snap_r = out_remainder;
    check_eq("t5_quot", 32'(snap_q), 32'hF2);
    check_eq("t5_rem",  32'(snap_r), 32'hFE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("t5_hold_valid", 32'(out_valid),     32'd1);
      check_eq("t5_hold_quot",  32'(out_quotient),  32'(snap_q));
      check_eq("t5_hold_rem",   32'(out_remainder), 32'(snap_r));
      check_eq("t5_in_ready",   32'(in_ready),      32'd0);
    end
    hs0 = n_hs;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    check_eq("t5_single_hs", 32'(n_hs - hs0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 127));
      rb = 8'($urandom_range(1, 255));
      send(1'($urandom_range(0, 1)), ra, rb, accs[i]);
    end
    for (int i = 1; i < 4; i++) check_eq("t5_b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd4);
    drain();

    // 6: reset while in WAIT, stale div_ready afterwards
    stall = 1'b1;
    send(1'b1, 8'hE0, 8'h03, acc);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("t6_wait_hold", 32'(dbg_state), 32'(WAIT));
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t6_rst_state",    32'(dbg_state), 32'(IDLE));
    check_eq("t6_rst_in_ready", 32'(in_ready),  32'd1);
    check_eq("t6_rst_start",    32'(div_start), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("t6_no_valid", 32'(out_valid), 32'd0);
      check_eq("t6_idle",     32'(dbg_state), 32'(IDLE));
    end
    send(1'b1, 8'hE0, 8'h03, acc);
    wait_valid(lat);
    check_eq("t6_latency", 32'(lat), 32'd3);
    check_eq("t6_quot", 32'(out_quotient),  32'hF6);
    check_eq("t6_rem",  32'(out_remainder), 32'hFE);
    drain();

    // random mix, including special cases and output backpressure
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: rb = 8'h00;
        1: begin rs = 1'b1; ra = 8'h80; rb = 8'hFF; end
        2: rb = 8'hFF;
        default: ;
      endcase
      out_ready = 1'($urandom_range(0, 1));
      send(rs, ra, rb, acc);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
